ccb_bus_arbiter: RTL and testbench

Synchronous round-robin arbiter for the shared CCB bus.
- Accepts level requests from NUM_REQ task units.
- Issues a one-hot grant and holds it until the owner drops its request.
- Inserts a one-cycle bus turnaround gap between owners.
- Replaces ad-hoc edge-triggered request capture with a single-clock, reset-defined controller in the fastClk domain.

---
 rtl/ccb_pkg.sv | 24 ++
 rtl/ccb_rr_pick.sv | 40 ++++
 rtl/ccb_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ccb_bus_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ccb_pkg.sv
// Shared types and defaults for the CCB bus arbiter.
package ccb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } ccb_state_e;

    localparam int CCB_NUM_REQ  = 4;
    localparam int CCB_ID_W     = 2;
    localparam int CCB_MAX_HOLD = 255;

    // Index of the set bit in a one-hot vector of up to 8 requesters; 0 for an empty vector.
    function automatic logic [2:0] ccb_onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ccb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_owner_i, wrapping.
module ccb_rr_pick
    import ccb_pkg::*;
#(
    parameter int NUM_REQ = CCB_NUM_REQ,
    parameter int ID_W    = CCB_ID_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_owner_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    winner_o
);

    logic [NUM_REQ-1:0] pick_oh_s;
    logic [7:0]         pick_oh8_s;
    logic               found_s;
    int                 idx_s;

    // Walk the requesters in round-robin order and keep only the first hit.
    always_comb begin
        pick_oh_s = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s            = (int'(last_owner_i) + i) % NUM_REQ;
            pick_oh_s[idx_s] = req_i[idx_s] & ~found_s;
            found_s          = found_s | req_i[idx_s];
        end
    end

    // Widen the one-hot pick so the shared conversion helper can be reused.
    always_comb begin
        pick_oh8_s                = 8'd0;
        pick_oh8_s[NUM_REQ-1:0]   = pick_oh_s;
    end

    assign valid_o  = found_s;
    assign winner_o = ID_W'(ccb_onehot_to_idx(pick_oh8_s));

endmodule

// File: rtl/ccb_bus_arbiter.sv
// Round-robin CCB bus arbiter with hold-until-release grants and a one-cycle turnaround gap.
// Optional grant timeout and revoke mask are enabled by defining CCB_TIMEOUT_EN.
module ccb_bus_arbiter
    import ccb_pkg::*;
#(
    parameter int NUM_REQ  = CCB_NUM_REQ,
    parameter int ID_W     = CCB_ID_W,
    parameter int MAX_HOLD = CCB_MAX_HOLD
) (
    input  logic               fastClk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    owner_id,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [ID_W-1:0]    LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_OH   = NUM_REQ'(1);

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((2 ** ID_W) < NUM_REQ) || (MAX_HOLD < 1)) begin : g_cfg_err
        $error("ccb_bus_arbiter: illegal parameter combination");
    end

    ccb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0] pick_req_s;
    logic               pick_valid_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic               owner_req_s;

`ifdef CCB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hold_inc_s;
    logic [NUM_REQ-1:0] block_q, block_d;
    logic               terr_q, terr_d;

    // A revoked requester stays invisible to the picker until it has dropped req once.
    assign pick_req_s  = req & ~block_q;
    assign hold_inc_s  = hold_q + HOLD_W'(1);
    assign timeout_err = terr_q;
`else
    assign pick_req_s  = req;
    assign timeout_err = 1'b0;
`endif

    // The owner keeps the bus only while its own request line stays high.
    assign owner_req_s = |(req & gnt_q);

    ccb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i        (pick_req_s),
        .last_owner_i (last_q),
        .valid_o      (pick_valid_s),
        .winner_o     (pick_idx_s)
    );

    // Next-state and registered-output logic for IDLE -> GRANT -> GAP.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        last_d  = last_q;
`ifdef CCB_TIMEOUT_EN
        hold_d  = hold_q;
        block_d = block_q & req;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    gnt_d   = ONE_OH << pick_idx_s;
                    owner_d = pick_idx_s;
                    busy_d  = 1'b1;
                    last_d  = pick_idx_s;
                    state_d = GRANT;
`ifdef CCB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = GAP;
                end
`ifdef CCB_TIMEOUT_EN
                else if (hold_inc_s == HOLD_W'(MAX_HOLD)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    block_d = (block_q & req) | gnt_q;
                    state_d = GAP;
                end else begin
                    hold_d  = hold_inc_s;
                end
`else
                else begin
                    state_d = GRANT;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge fastClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

`ifdef CCB_TIMEOUT_EN
    // Hold counter, revoke mask and error pulse registers.
    always_ff @(posedge fastClk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            block_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            block_q <= block_d;
            terr_q  <= terr_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ccb_bus_arbiter.sv
// Directed self-checking bench for ccb_bus_arbiter (default build, NUM_REQ=4).
module tb_ccb_bus_arbiter;

    logic       fastClk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner_id;
    logic       busy;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    ccb_bus_arbiter #(
        .NUM_REQ  (4),
        .ID_W     (2),
        .MAX_HOLD (255)
    ) dut (
        .fastClk     (fastClk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt         (gnt),
        .owner_id    (owner_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 fastClk = ~fastClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] g, input logic [1:0] id, input logic b);
        chk({tag, "_gnt"},   32'(gnt),         32'(g));
        chk({tag, "_owner"}, 32'(owner_id),    32'(id));
        chk({tag, "_busy"},  32'(busy),        32'(b));
        chk({tag, "_terr"},  32'(timeout_err), 32'd0);
    endtask

    task automatic tick();
        @(posedge fastClk);
        #1;
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    endtask

    logic [3:0] oh;
    int         o;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        chk_bus("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Single requester: grant latency, release, regrant after the gap
        tick();
        req = 4'b0001;
        tick();
        chk_bus("t1_grant", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk_bus("t1_release", 4'b0000, 2'd0, 1'b0);
        req = 4'b0001;
        tick();
        chk_bus("t1_gap", 4'b0000, 2'd0, 1'b0);
        tick();
        chk_bus("t1_regrant", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // Wrap-around: last owner 2, requests 0 and 2 together go to 0
        req = 4'b0100;
        tick();
        chk_bus("t3_own2", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        req = 4'b0101;
        tick();
        chk_bus("t3_gap", 4'b0000, 2'd2, 1'b0);
        tick();
        chk_bus("t3_wrap", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // No pre-emption: owner 1 holds while requester 3 waits
        req = 4'b0010;
        tick();
        chk_bus("t4_own1", 4'b0010, 2'd1, 1'b1);
        req = 4'b1010;
        tick();
        chk_bus("t4_hold_a", 4'b0010, 2'd1, 1'b1);
        tick();
        chk_bus("t4_hold_b", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        tick();
        chk_bus("t4_release", 4'b0000, 2'd1, 1'b0);
        tick();
        chk_bus("t4_gap", 4'b0000, 2'd1, 1'b0);
        tick();
        chk_bus("t4_own3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // All four requesting, each owner releases after 3 cycles
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            o  = k % 4;
            oh = 4'b0001 << o;
            chk_bus("t2_grant", oh, 2'(o), 1'b1);
            tick();
            chk_bus("t2_hold1", oh, 2'(o), 1'b1);
            tick();
            chk_bus("t2_hold2", oh, 2'(o), 1'b1);
            req = 4'b1111 & ~oh;
            tick();
            chk_bus("t2_release", 4'b0000, 2'(o), 1'b0);
            req = 4'b1111;
            tick();
            chk_bus("t2_gap", 4'b0000, 2'(o), 1'b0);
            tick();
        end
        chk_bus("t2_next", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset in the middle of a grant
        req = 4'b0100;
        tick();
        chk_bus("t5_own2", 4'b0100, 2'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bus("t5_async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1111;
        tick();
        chk_bus("t5_in_rst", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_bus("t5_first0", 4'b0001, 2'd0, 1'b1);
        tick();
        chk_bus("t5_hold0", 4'b0001, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
